// File: rtl/fxp_mult_seq.sv
// fxp_mult_seq: sequential signed fixed-point shift-add multiplier with round-half-away and saturation
module fxp_mult_seq #(
   parameter int BIT_WIDTH = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] x,
   input  logic [BIT_WIDTH-1:0] y,
   output logic                 busy,
   output logic                 done,
   output logic [BIT_WIDTH-1:0] product,
   output logic                 ovf
);
   localparam int AW = 2 * BIT_WIDTH;
   localparam int CW = $clog2(BIT_WIDTH);
   typedef enum logic [1:0] {IDLE, MUL, RND} state_t;
   state_t               state_q, state_d;
   logic                 sign_q, sign_d, done_q, done_d, ovf_q, ovf_d;
   logic [AW-1:0]        mx_q, mx_d, acc_q, acc_d;
   logic [BIT_WIDTH-1:0] my_q, my_d, product_q, product_d, ax, ay, res;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        m, max_pos;
   logic                 accept, in_mul, sat_pos, sat_neg;
   assign busy    = state_q != IDLE;
   assign done    = done_q;
   assign product = product_q;
   assign ovf     = ovf_q;
   // next-state: latch magnitudes on accept, shift-add one multiplier bit per MUL cycle, round/saturate in RND
   always_comb begin
      accept    = state_q == IDLE && start;
      in_mul    = state_q == MUL;
      ax        = x[BIT_WIDTH-1] ? -x : x;
      ay        = y[BIT_WIDTH-1] ? -y : y;
      m         = (acc_q + (AW'(1) << (FRAC_BITS - 1))) >> FRAC_BITS;
      max_pos   = (AW'(1) << (BIT_WIDTH - 1)) - AW'(1);
      sat_pos   = !sign_q && m > max_pos;
      sat_neg   = sign_q && m > max_pos + AW'(1);
      res       = sat_pos ? {1'b0, {(BIT_WIDTH-1){1'b1}}} :
                  sat_neg ? {1'b1, {(BIT_WIDTH-1){1'b0}}} :
                  sign_q  ? -m[BIT_WIDTH-1:0] : m[BIT_WIDTH-1:0];
      state_d   = state_q == IDLE ? (start ? MUL : IDLE) :
                  in_mul ? (cnt_q == CW'(BIT_WIDTH - 1) ? RND : MUL) : IDLE;
      sign_d    = accept ? x[BIT_WIDTH-1] ^ y[BIT_WIDTH-1] : sign_q;
      mx_d      = accept ? {{BIT_WIDTH{1'b0}}, ax} : in_mul ? mx_q << 1 : mx_q;
      my_d      = accept ? ay : in_mul ? my_q >> 1 : my_q;
      acc_d     = accept ? '0 : in_mul ? acc_q + (my_q[0] ? mx_q : '0) : acc_q;
      cnt_d     = accept ? '0 : in_mul ? cnt_q + CW'(1) : cnt_q;
      product_d = state_q == RND ? res : product_q;
      ovf_d     = state_q == RND ? (sat_pos || sat_neg) : ovf_q;
      done_d    = state_q == RND;
   end
   // state and datapath registers; reset clears outputs and abandons any operation in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sign_q    <= 1'b0;
         mx_q      <= '0;
         my_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         mx_q      <= mx_d;
         my_q      <= my_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end
endmodule

// File: tb/tb_fxp_mult_seq.sv
// tb_fxp_mult_seq: directed vectors plus a cycle-level reference model for fxp_mult_seq
module tb_fxp_mult_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [15:0] x = '0, y = '0;
   logic        busy, done, ovf;
   logic [15:0] product;
   int          checks = 0, failures = 0;
   bit          en = 1'b0;

   fxp_mult_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
                     .busy(busy), .done(done), .product(product), .ovf(ovf));

   always #5 clk = ~clk;

   function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
      longint p, m;
      logic   s;
      p = longint'($signed(a)) * longint'($signed(b));
      s = a[15] ^ b[15];
      m = ((p < 0 ? -p : p) + 128) >>> 8;
      if (!s && m > 32767) return {1'b1, 16'h7FFF};
      if (s && m > 32768) return {1'b1, 16'h8000};
      return {1'b0, s ? 16'(-m) : 16'(m)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // reference model: an accepted op completes 17 edges later, results held until then
   int          rem = 0;
   logic        m_done = 0, m_ovf = 0, p_ovf = 0;
   logic [15:0] m_prod = 0, p_prod = 0;
   always @(posedge clk) begin
      if (!rst_n) begin
         rem = 0; m_done = 0; m_prod = 0; m_ovf = 0;
      end else begin
         m_done = 0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               m_done = 1; m_prod = p_prod; m_ovf = p_ovf;
            end
         end else if (start) begin
            {p_ovf, p_prod} = model(x, y);
            rem = 17;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("cyc busy", {31'b0, busy}, {31'b0, rem > 0});
         chk("cyc done", {31'b0, done}, {31'b0, m_done});
         chk("cyc product", {16'b0, product}, {16'b0, m_prod});
         chk("cyc ovf", {31'b0, ovf}, {31'b0, m_ovf});
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ep,
                        input logic eo, input int pulse_at, input string nm);
      int n;
      start = 1; x = a; y = b;
      @(posedge clk); #1;
      start = 0; x = 16'($urandom); y = 16'($urandom);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         start = (n == pulse_at);
         x = 16'($urandom); y = 16'($urandom);
      end
      start = 0;
      chk({nm, " latency"}, n, 17);
      chk({nm, " product"}, {16'b0, product}, {16'b0, ep});
      chk({nm, " ovf"}, {31'b0, ovf}, {31'b0, eo});
      @(posedge clk); #1;
      chk({nm, " done pulse"}, {31'b0, done}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int last, dn, n;
      @(posedge clk); #1;
      en = 1;
      @(posedge clk); #1;
      chk("reset busy", {31'b0, busy}, 0);
      chk("reset done", {31'b0, done}, 0);
      chk("reset product", {16'b0, product}, 0);
      chk("reset ovf", {31'b0, ovf}, 0);
      rst_n = 1;
      @(posedge clk); #1;
      do_op(16'h0100, 16'h0100, 16'h0100, 0, -1, "one");
      do_op(16'hFE80, 16'h0200, 16'hFD00, 0, -1, "neg");
      do_op(16'h8000, 16'h0100, 16'h8000, 0, -1, "minexact");
      do_op(16'h0000, 16'h8000, 16'h0000, 0, -1, "zero");
      do_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 1, -1, "satpos");
      do_op(16'h8000, 16'h8000, 16'h7FFF, 1, -1, "satminmin");
      do_op(16'h7FFF, 16'h8001, 16'h8000, 1, -1, "satneg");
      do_op(16'h0001, 16'h0080, 16'h0001, 0, -1, "rndhalf");
      do_op(16'hFFFF, 16'h0080, 16'hFFFF, 0, -1, "rndhalfneg");
      do_op(16'h0001, 16'h007F, 16'h0000, 0, -1, "rnddown");
      do_op(16'hFFFF, 16'h007F, 16'h0000, 0, -1, "negzero");
      do_op(16'h0100, 16'h0200, 16'h0200, 0, 5, "midpulse");
      do_op(16'h0300, 16'hFF00, 16'hFD00, 0, 16, "rndpulse");
      // start held high with operands changing every cycle
      start = 1; x = 16'h0180; y = 16'h0200;
      last = -1; dn = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         x = 16'h0100 + 16'(k * 37);
         y = 16'hFF00 - 16'(k * 53);
         if (done) begin
            if (last >= 0) chk("stream gap", k - last, 18);
            else chk("stream first product", {16'b0, product}, 32'h0300);
            last = k;
            dn++;
         end
      end
      start = 0;
      chk("stream dones", dn, 3);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("stream drain done", {31'b0, done}, 1);
      // reset during MUL iteration 5
      start = 1; x = 16'h0200; y = 16'h0300;
      @(posedge clk); #1;
      start = 0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      chk("abort busy", {31'b0, busy}, 0);
      chk("abort product", {16'b0, product}, 0);
      chk("abort ovf", {31'b0, ovf}, 0);
      dn = 0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      chk("abort no done", dn, 0);
      do_op(16'h0200, 16'h0300, 16'h0600, 0, -1, "afterabort");
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
